// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush and saturating stall/flush performance counters.
module pipe_stage_skid #(
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 16,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    // Flush wins over any handshake; an out_fire in a flush cycle is simply
    // treated as consumed downstream.
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            state_next = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_next = in_data;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_next = in_data;
                    end else if (in_fire) begin
                        skid_data_next = in_data;
                        state_next     = TWO;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_data_next = skid_data_reg;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so in_ready has no
    // combinational path from out_ready.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
            out_valid_reg <= (state_next != EMPTY);
            in_ready_reg  <= (state_next != TWO);
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_data_reg;
    assign occupancy = state_reg;

    // Counter 0 tracks stall cycles, counter 1 tracks flush cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = out_valid_reg & ~out_ready;
    assign cnt_inc[1] = flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge Clk) begin
                if (Reset || cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
                    cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: instance a uses defaults, instance b
// retains data on flush and has 4-bit counters; both see the same stimulus.
module tb_pipe_stage_skid;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [1:0]  occ_a, occ_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pipe_stage_skid #(.DATA_W(32), .CNT_W(16), .ZERO_ON_FLUSH(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(occ_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_stage_skid #(.DATA_W(32), .CNT_W(4), .ZERO_ON_FLUSH(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(occ_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; cnt_clr = 1'b0;
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (occ_a !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occ_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready_a); end
        total++; if (out_data_a !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%0h want=0", out_data_a); end
        total++; if (stall_a !== 16'd0 || flush_a !== 16'd0) begin bad++; $display("FAIL rst_cnts got=%0d/%0d want=0/0", stall_a, flush_a); end
        $display("reset: occ=%0d out_valid=%0b in_ready=%0b", occ_a, out_valid_a, in_ready_a);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
            total++; if (out_data_a !== 32'(i) || out_valid_a !== 1'b1) begin bad++; $display("FAIL b2b_data got=%0h/%0b want=%0h/1", out_data_a, out_valid_a, i); end
            total++; if (occ_a !== 2'd1 || in_ready_a !== 1'b1) begin bad++; $display("FAIL b2b_occ got=%0d/%0b want=1/1", occ_a, in_ready_a); end
            $display("b2b: in=%0h out=%0h occ=%0d", i, out_data_a, occ_a);
        end
        in_valid = 1'b0;
        step();
        total++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0d/%0b want=0/0", occ_a, out_valid_a); end
        total++; if (stall_a !== 16'd0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stall_a); end
    endtask

    task automatic test_skid();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA;
        step();
        total++; if (occ_a !== 2'd1 || out_data_a !== 32'hA) begin bad++; $display("FAIL skid_one got=%0d/%0h want=1/a", occ_a, out_data_a); end
        in_data = 32'hB;
        step();
        total++; if (occ_a !== 2'd2 || in_ready_a !== 1'b0) begin bad++; $display("FAIL skid_two got=%0d/%0b want=2/0", occ_a, in_ready_a); end
        in_data = 32'hC;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (occ_a !== 2'd2 || out_data_a !== 32'hA) begin bad++; $display("FAIL skid_hold got=%0d/%0h want=2/a", occ_a, out_data_a); end
        end
        out_ready = 1'b1;
        step();
        total++; if (out_data_a !== 32'hB || occ_a !== 2'd1 || in_ready_a !== 1'b1) begin bad++; $display("FAIL skid_out_b got=%0h/%0d/%0b want=b/1/1", out_data_a, occ_a, in_ready_a); end
        step();
        total++; if (out_data_a !== 32'hC || occ_a !== 2'd1) begin bad++; $display("FAIL skid_out_c got=%0h/%0d want=c/1", out_data_a, occ_a); end
        in_valid = 1'b0;
        step();
        total++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL skid_drain got=%0d/%0b want=0/0", occ_a, out_valid_a); end
        total++; if (stall_a !== 16'd3) begin bad++; $display("FAIL skid_stall got=%0d want=3", stall_a); end
        $display("skid: order a,b,c stall=%0d", stall_a);
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        total++; if (occ_a !== 2'd2) begin bad++; $display("FAIL fl_fill got=%0d want=2", occ_a); end
        flush = 1'b1; in_data = 32'h33;
        step();
        total++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL fl_state got=%0d/%0b/%0b want=0/0/1", occ_a, out_valid_a, in_ready_a); end
        total++; if (out_data_a !== 32'h0) begin bad++; $display("FAIL fl_zero got=%0h want=0", out_data_a); end
        total++; if (out_data_b !== 32'h11 || out_valid_b !== 1'b0) begin bad++; $display("FAIL fl_keep got=%0h/%0b want=11/0", out_data_b, out_valid_b); end
        total++; if (flush_a !== 16'd1 || flush_b !== 4'd1) begin bad++; $display("FAIL fl_cnt got=%0d/%0d want=1/1", flush_a, flush_b); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        total++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin bad++; $display("FAIL fl_no33 got=%0b/%0d want=0/0", out_valid_a, occ_a); end
        // in_ready is high here, so this push would fire if flush did not drop it
        in_valid = 1'b1; in_data = 32'h44; flush = 1'b1;
        step();
        total++; if (occ_a !== 2'd0 || out_valid_b !== 1'b0 || out_data_b !== 32'h11) begin bad++; $display("FAIL fl_drop got=%0d/%0b/%0h want=0/0/11", occ_a, out_valid_b, out_data_b); end
        total++; if (flush_a !== 16'd2) begin bad++; $display("FAIL fl_cnt2 got=%0d want=2", flush_a); end
        flush = 1'b0; in_valid = 1'b0;
        step();
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL fl_after got=%0b want=0", out_valid_a); end
        $display("flush: occ=%0d data_a=%0h data_b=%0h fcnt=%0d", occ_a, out_data_a, out_data_b, flush_a);
    endtask

    task automatic test_stall_sat();
        do_reset();
        in_valid = 1'b1; in_data = 32'h5;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        total++; if (stall_b !== 4'd15) begin bad++; $display("FAIL sat_b got=%0d want=15", stall_b); end
        total++; if (stall_a !== 16'd20) begin bad++; $display("FAIL sat_a got=%0d want=20", stall_a); end
        total++; if (out_data_a !== 32'h5 || out_valid_a !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0h/%0b want=5/1", out_data_a, out_valid_a); end
        cnt_clr = 1'b1;
        step();
        total++; if (stall_b !== 4'd0 || stall_a !== 16'd0) begin bad++; $display("FAIL clr got=%0d/%0d want=0/0", stall_b, stall_a); end
        cnt_clr = 1'b0;
        step();
        total++; if (stall_b !== 4'd1) begin bad++; $display("FAIL clr_inc got=%0d want=1", stall_b); end
        $display("stall: b=%0d a=%0d", stall_b, stall_a);
    endtask

    task automatic test_reset_priority();
        do_reset();
        in_valid = 1'b1; in_data = 32'h77;
        step();
        in_data = 32'h88;
        step();
        total++; if (occ_a !== 2'd2) begin bad++; $display("FAIL rp_fill got=%0d want=2", occ_a); end
        in_valid = 1'b0; flush = 1'b1; Reset = 1'b1;
        step();
        total++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL rp_state got=%0d/%0b/%0b want=0/0/1", occ_a, out_valid_a, in_ready_a); end
        total++; if (out_data_b !== 32'h0) begin bad++; $display("FAIL rp_data got=%0h want=0", out_data_b); end
        total++; if (flush_a !== 16'd0 || stall_a !== 16'd0) begin bad++; $display("FAIL rp_cnt got=%0d/%0d want=0/0", flush_a, stall_a); end
        Reset = 1'b0; flush = 1'b0;
        $display("reset_priority: occ=%0d fcnt=%0d", occ_a, flush_a);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid();
        test_flush();
        test_stall_sat();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
